// File: rtl/ars_aes_pkg.sv
// Shared AES definitions for the ars decryption datapath.
// Provides byte/column/state typedefs, the low byte of the AES field
// polynomial (0x11B), the GF(2^8) xtime helper and the FSM state encoding
// used by the column-serial InvMixColumns unit.
package ars_aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    localparam aes_byte_t AES_POLY_LOW = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic aes_byte_t xtime(input aes_byte_t v);
        return {v[6:0], 1'b0} ^ (v[7] ? AES_POLY_LOW : 8'h00);
    endfunction

endpackage

// File: rtl/ars_inv_mix_pair.sv
// Combinational InvMixColumns byte-pair generator.
// Ports:
//   a, b, c, d : column bytes, row 0 first
//   sel        : 0 -> (x0, x1), 1 -> (x2, x3)
//   x_hi, x_lo : the selected output byte pair, upper row first
// Selecting the second pair rotates the column by two bytes, which maps the
// x0/x1 equations onto x2/x3 because the inverse matrix is circulant.
module ars_inv_mix_pair
    import ars_aes_pkg::*;
(
    input  aes_byte_t a,
    input  aes_byte_t b,
    input  aes_byte_t c,
    input  aes_byte_t d,
    input  logic      sel,
    output aes_byte_t x_hi,
    output aes_byte_t x_lo
);

    // Multiply by a constant whose set bits select v, 2v, 4v, 8v.
    function automatic aes_byte_t mul_k(input aes_byte_t v, input logic [3:0] k);
        aes_byte_t v2;
        aes_byte_t v4;
        aes_byte_t v8;
        v2 = xtime(v);
        v4 = xtime(v2);
        v8 = xtime(v4);
        return (k[3] ? v8 : 8'h00) ^ (k[2] ? v4 : 8'h00) ^
               (k[1] ? v2 : 8'h00) ^ (k[0] ? v  : 8'h00);
    endfunction

    aes_byte_t p, q, r, s;

    always_comb begin
        p = sel ? c : a;
        q = sel ? d : b;
        r = sel ? a : c;
        s = sel ? b : d;
    end

    assign x_hi = mul_k(p, 4'hE) ^ mul_k(q, 4'hB) ^ mul_k(r, 4'hD) ^ mul_k(s, 4'h9);
    assign x_lo = mul_k(p, 4'h9) ^ mul_k(q, 4'hE) ^ mul_k(r, 4'hB) ^ mul_k(s, 4'hD);

endmodule

// File: rtl/ars_inv_mixcolumn_unit.sv
// Column-serial AES InvMixColumns engine.
// Accepts one 128-bit state on in_valid/in_ready, computes InvMixColumns
// in place into a result register, and presents it on out_valid/out_ready.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready high only in IDLE)
//   in_data             : state, byte k = in_data[127-8k -: 8]
//   out_valid/out_ready : output handshake (out_valid high only in DONE)
//   out_data            : InvMixColumns(in_data), same byte order
// Build option ARS_INVMIX_FULLCOL_EN: compute a whole column per cycle
// (4 compute cycles) instead of one byte pair per cycle (8 compute cycles).
module ars_inv_mixcolumn_unit
    import ars_aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    fsm_state_t state_q, state_d;
    logic [1:0] col_q, col_d;
    aes_state_t src_q, src_d;
    aes_state_t res_q, res_d;

    // Source bytes always come from the latched input copy.
    logic [6:0] src_msb;
    aes_col_t   src_col;

    assign src_msb = 7'd127 - {col_q, 5'd0};
    assign src_col = src_q[src_msb -: 32];

`ifdef ARS_INVMIX_FULLCOL_EN
    aes_byte_t x0, x1, x2, x3;

    ars_inv_mix_pair u_pair_lo (
        .a(src_col[31:24]), .b(src_col[23:16]), .c(src_col[15:8]), .d(src_col[7:0]),
        .sel(1'b0), .x_hi(x0), .x_lo(x1)
    );

    ars_inv_mix_pair u_pair_hi (
        .a(src_col[31:24]), .b(src_col[23:16]), .c(src_col[15:8]), .d(src_col[7:0]),
        .sel(1'b1), .x_hi(x2), .x_lo(x3)
    );
`else
    logic       half_q, half_d;
    logic [6:0] dst_msb;
    aes_byte_t  y_hi, y_lo;

    assign dst_msb = 7'd127 - {col_q, half_q, 4'd0};

    ars_inv_mix_pair u_pair (
        .a(src_col[31:24]), .b(src_col[23:16]), .c(src_col[15:8]), .d(src_col[7:0]),
        .sel(half_q), .x_hi(y_hi), .x_lo(y_lo)
    );
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        src_d   = src_q;
        res_d   = res_q;
`ifndef ARS_INVMIX_FULLCOL_EN
        half_d  = half_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    col_d   = 2'd0;
`ifndef ARS_INVMIX_FULLCOL_EN
                    half_d  = 1'b0;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef ARS_INVMIX_FULLCOL_EN
                res_d[src_msb -: 32] = {x0, x1, x2, x3};
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
`else
                res_d[dst_msb -: 16] = {y_hi, y_lo};
                half_d = ~half_q;
                if (half_q) begin
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
`ifndef ARS_INVMIX_FULLCOL_EN
            half_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            src_q   <= src_d;
            res_q   <= res_d;
`ifndef ARS_INVMIX_FULLCOL_EN
            half_q  <= half_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;

endmodule

// File: tb/tb_ars_inv_mixcolumn_unit.sv
module tb_ars_inv_mixcolumn_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    ars_inv_mixcolumn_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

`ifdef ARS_INVMIX_FULLCOL_EN
    localparam int LAT = 4;
    localparam int PERIOD = 6;
`else
    localparam int LAT = 8;
    localparam int PERIOD = 10;
`endif

    // GF(2^8) multiply, shift-and-add with reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] aa;
        logic [7:0] bb;
        acc = 8'h00;
        aa = x;
        bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) acc = acc ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    // Circulant column mix: out[r] = sum_j m[(j-r) mod 4] * in[j].
    function automatic logic [127:0] mix_state(input logic [127:0] s, input logic [31:0] m);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(m[31 - 8*((j - r + 4) % 4) -: 8], s[127 - 8*(4*c + j) -: 8]);
                end
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return mix_state(s, 32'h0E0B0D09);
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        return mix_state(s, 32'h02030101);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] s, output int e0);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = s;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        chk("send_ready", 128'(in_ready), 128'(1));
        step();
        e0 = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int ev);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        chk("out_valid_wait", 128'(out_valid), 128'(1));
        ev = cyc;
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [127:0] s, e, held, ra, rb, ref_a, ref_b;
        int e0, ev, c0, c1, n;
        logic got_a;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        rst = 1'b0;
        step();
        chk("idle_in_ready", 128'(in_ready), 128'(1));

        // Single column with latency check
        s = {32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101};
        e = {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101};
        send(s, e0);
        chk("single_busy_in_ready", 128'(in_ready), 128'(0));
        wait_out(ev);
        chk("single_latency", 128'(ev - e0), 128'(LAT));
        chk("single_data", out_data, e);
        chk("single_model", inv_mix(s), e);
        take();
        chk("single_post_in_ready", 128'(in_ready), 128'(1));
        chk("single_post_out_valid", 128'(out_valid), 128'(0));

        // FIPS-197 columns
        s = {32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6};
        e = {32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6};
        send(s, e0);
        wait_out(ev);
        chk("fips_latency", 128'(ev - e0), 128'(LAT));
        chk("fips_data", out_data, e);
        take();

        // Backpressure: output held, new in_valid ignored until transfer
        s = {$urandom, $urandom, $urandom, $urandom};
        e = inv_mix(s);
        send(s, e0);
        wait_out(ev);
        held = out_data;
        chk("bp_data", held, e);
        in_valid = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_out_data", out_data, held);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_xfer_in_ready", 128'(in_ready), 128'(1));
        chk("bp_xfer_out_valid", 128'(out_valid), 128'(0));
        step();
        in_valid = 1'b0;
        chk("bp_next_accepted", 128'(in_ready), 128'(0));
        e = inv_mix(in_data);
        wait_out(ev);
        chk("bp_next_data", out_data, e);
        take();

        // Back-to-back with in_valid and out_ready held high
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        ref_a = inv_mix(ra);
        ref_b = inv_mix(rb);
        out_ready = 1'b1;
        send(ra, c0);
        in_valid = 1'b1;
        in_data = rb;
        got_a = 1'b0;
        c1 = c0;
        n = 0;
        while (n < 50) begin
            if (out_valid && !got_a) begin
                chk("b2b_first_data", out_data, ref_a);
                got_a = 1'b1;
            end
            if (in_ready && got_a) begin
                step();
                c1 = cyc;
                break;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("b2b_first_seen", 128'(got_a), 128'(1));
        chk("b2b_interval", 128'(c1 - c0), 128'(PERIOD));
        wait_out(ev);
        chk("b2b_second_latency", 128'(ev - c1), 128'(LAT));
        chk("b2b_second_data", out_data, ref_b);
        step();
        out_ready = 1'b0;
        chk("b2b_drained", 128'(out_valid), 128'(0));

        // Asynchronous reset during BUSY
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, e0);
        repeat (4) step();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_data", out_data, 128'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("midrst_no_pulse", 128'(out_valid), 128'(0));
        end
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, e0);
        wait_out(ev);
        chk("postrst_latency", 128'(ev - e0), 128'(LAT));
        chk("postrst_data", out_data, inv_mix(s));
        take();

        // Round trip through the forward model
        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            send(fwd_mix(s), e0);
            wait_out(ev);
            chk("roundtrip", out_data, s);
            take();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
